rgb_pwm_fader: RTL and testbench
================================

# rgb_pwm_fader

Downstream stage of the light sequencer. Takes the 3-bit on/off colour code (`rgb_target`) and drives the three LED pins with per-channel PWM. Each channel fades linearly between off and full brightness instead of snapping, so colour changes from the sequencer become smooth cross-fades. Its outputs connect directly to the board RGB LED pins.

## Interface
- `PWM_BITS`, default 8: width of the PWM counter and the duty registers; the PWM period is 2^PWM_BITS cycles.
- `STEP_TICKS`, default 1000: clock cycles between duty steps; must be ≥ 1.
- `clk` in 1: system clock, the single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: global enable; when low, outputs are blanked and fades freeze.
- `rgb_target` in 3: per-channel target; 1 = full on, 0 = off. Sampled every cycle, no handshake.
- `led_pwm` out 3: registered PWM outputs, one per channel.
- `fading` out 1: high while any channel's duty differs from its target level.

## Operation
- Reset (async assert of `rst_n` low): all registers clear immediately.
  - PWM counter `cnt` = 0, step timer = 0.
  - `duty[2:0]` = 0, shadow duties `shd[2:0]` = 0.
  - `led_pwm` = 3'b000.
  - `fading` = 0 if `rgb_target` = 000 (combinational from duty vs target).
- Target level: `lvl[i]` = all-ones (2^PWM_BITS − 1) if `rgb_target[i]`, else 0.
- PWM counter:
  - Free-running 0 … 2^PWM_BITS − 1, wraps to 0.
  - Runs regardless of `ena`.
- Step timer:
  - Counts 0 … STEP_TICKS − 1 while `ena` = 1; the step tick is asserted in the cycle where it equals STEP_TICKS − 1, after which it wraps to 0.
  - Held at 0 while `ena` = 0.
  - STEP_TICKS = 1 gives a step every enabled cycle.
- Duty update on a step tick, per channel independently:
  - `duty` < `lvl`: `duty` + 1.
  - `duty` > `lvl`: `duty` − 1.
  - Equal: hold.
  - No overflow or underflow is possible: values saturate at `lvl`.
- Target change mid-fade: the channel reverses direction from its current duty on the next step tick. No jump, no restart.
- Shadow load: on the edge where `cnt` wraps from max to 0, `shd[i]` <= `duty[i]`. `duty` changes inside a period never alter that period's waveform.
- Output compare, registered each cycle:
  - `ena` = 0: `led_pwm[i]` <= 0.
  - Otherwise, if `shd[i]` = all-ones: `led_pwm[i]` <= 1 (constant on).
  - Otherwise: `led_pwm[i]` <= (`shd[i]` > `cnt`).
- `fading` = OR over i of (`duty[i]` != `lvl[i]`). Combinational and unaffected by `ena`.
- Simultaneous events:
  - Step tick and shadow load on the same edge: the shadow captures the pre-step duty.
  - `ena` falling on a step-tick cycle: the step is not taken.

## Timing
- `led_pwm` lags `cnt` by one cycle.
- Shadow duty D (0 < D < max) gives exactly D consecutive high cycles per 2^PWM_BITS-cycle period. They start one cycle after `cnt` = 0.
- D = 0: constantly low. D = max: constantly high.
- Full-swing fade (0 to max or back) takes (2^PWM_BITS − 1) × STEP_TICKS enabled cycles. The visible change appears at the next period boundary.
- `ena` low to `led_pwm` = 000: 1 cycle. `ena` high: compare output resumes the next cycle, and the step timer restarts from 0.
- `rst_n` assertion forces `led_pwm` to 000 without waiting for a clock edge. Deassertion is assumed synchronised externally; the first count happens on the first edge after release.

## Test plan
All cases use PWM_BITS = 4, STEP_TICKS = 3 (period 16, full fade 45 enabled cycles).
1. Reset: hold `rst_n` = 0 mid-cycle with `rgb_target` = 111 → `led_pwm` = 000 immediately. After release with `rgb_target` = 000 and `ena` = 1 → `led_pwm` stays 000 and `fading` = 0 for 100 cycles.
2. Fade up: `rgb_target` = 001 and `ena` = 1 after reset → `duty[0]` increments every 3 cycles and reaches 15 after 45 cycles, then `fading` = 0.
   - `led_pwm[0]` becomes constantly 1 from the first period after the shadow loads 15.
   - Bits 1 and 2 remain 0 throughout.
3. Duty accuracy: for each period during test 2, count `led_pwm[0]` high cycles → equals the `shd[0]` value loaded at that period's start, never a mid-period duty.
4. Reversal: `rgb_target` = 001 until `duty[0]` = 7, then 000 → `duty[0]` steps 7 down to 0 over 21 cycles with no jump; `led_pwm[0]` is constantly 0 after the following wrap.
5. Enable gating: drop `ena` at `duty` = 5 → `led_pwm` = 000 the next cycle and `duty` is frozen at 5. Raise `ena` → the first step occurs 3 cycles later, to 6.
6. Async reset mid-fade: set `rgb_target` = 110, wait 20 cycles, then pulse `rst_n` low between edges → `led_pwm` = 000 and all duties = 0 immediately. After release, the fade restarts from 0.

Source files
------------

// File: rtl/rgb_pwm_fader.sv
// Per-channel PWM driver for the board RGB LED: each channel's duty ramps linearly
// toward its on/off target, and the compare uses a shadow duty refreshed once per period.
module rgb_pwm_fader #(
  parameter int PWM_BITS   = 8,
  parameter int STEP_TICKS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] rgb_target,
  output logic [2:0] led_pwm,
  output logic       fading
);

  localparam int TMR_BITS = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};
  localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(STEP_TICKS - 1);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [TMR_BITS-1:0] tmr_q, tmr_d;
  logic [PWM_BITS-1:0] duty_q [3];
  logic [PWM_BITS-1:0] duty_d [3];
  logic [PWM_BITS-1:0] shd_q  [3];
  logic [PWM_BITS-1:0] shd_d  [3];
  logic [PWM_BITS-1:0] lvl    [3];
  logic [2:0]          led_pwm_q, led_pwm_d;
  logic                step_tick;
  logic                cnt_wrap;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      lvl[i] = rgb_target[i] ? DUTY_MAX : '0;
    end
    step_tick = ena && (tmr_q == TMR_LAST);
    cnt_wrap  = (cnt_q == DUTY_MAX);
  end

  // The step timer restarts from zero whenever the channel is disabled, so a
  // re-enable always waits a full STEP_TICKS before the first duty change.
  always_comb begin
    cnt_d = cnt_q + PWM_BITS'(1);
    tmr_d = tmr_q;
    if (!ena || step_tick) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + TMR_BITS'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      duty_d[i] = duty_q[i];
      shd_d[i]  = shd_q[i];
      if (step_tick) begin
        if (duty_q[i] < lvl[i]) begin
          duty_d[i] = duty_q[i] + PWM_BITS'(1);
        end else if (duty_q[i] > lvl[i]) begin
          duty_d[i] = duty_q[i] - PWM_BITS'(1);
        end
      end
      // Shadow takes the pre-step duty when a step and a wrap coincide.
      if (cnt_wrap) begin
        shd_d[i] = duty_q[i];
      end
    end
  end

  always_comb begin
    led_pwm_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (!ena) begin
        led_pwm_d[i] = 1'b0;
      end else if (shd_q[i] == DUTY_MAX) begin
        led_pwm_d[i] = 1'b1;
      end else begin
        led_pwm_d[i] = (shd_q[i] > cnt_q);
      end
    end
  end

  always_comb begin
    fading = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fading = fading | (duty_q[i] != lvl[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      tmr_q     <= '0;
      led_pwm_q <= '0;
      for (int i = 0; i < 3; i++) begin
        duty_q[i] <= '0;
        shd_q[i]  <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      led_pwm_q <= led_pwm_d;
      for (int i = 0; i < 3; i++) begin
        duty_q[i] <= duty_d[i];
        shd_q[i]  <= shd_d[i];
      end
    end
  end

  assign led_pwm = led_pwm_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Self-checking bench for rgb_pwm_fader (PWM_BITS = 4, STEP_TICKS = 3): a cycle model
// feeds a scoreboard queue, plus a vector table and hand sequences for multi-cycle cases.
module tb_rgb_pwm_fader;

  localparam int PWM_BITS   = 4;
  localparam int STEP_TICKS = 3;
  localparam int MAXV       = 15;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [2:0] rgb_target;
  logic [2:0] led_pwm;
  logic       fading;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] led;
    logic       fad;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic       ena;
    logic [2:0] tgt;
    int         cycles;
    logic [2:0] exp_led;
    logic       exp_fad;
  } vec_t;
  vec_t vecs[8];

  // Reference model state, advanced once per rising edge.
  int         m_cnt;
  int         m_tmr;
  int         m_duty [3];
  int         m_shd  [3];
  logic [2:0] m_led;

  rgb_pwm_fader #(
    .PWM_BITS  (PWM_BITS),
    .STEP_TICKS(STEP_TICKS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .rgb_target(rgb_target),
    .led_pwm   (led_pwm),
    .fading    (fading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_tmr = 0;
    m_led = 3'b000;
    for (int i = 0; i < 3; i++) begin
      m_duty[i] = 0;
      m_shd[i]  = 0;
    end
  endtask

  function automatic logic model_fading();
    logic f;
    f = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (m_duty[i] != (rgb_target[i] ? MAXV : 0)) f = 1'b1;
    end
    return f;
  endfunction

  task automatic model_clock();
    bit         tick;
    logic [2:0] nled;
    int         goal;
    tick = ena && (m_tmr == STEP_TICKS - 1);
    for (int i = 0; i < 3; i++) begin
      if (!ena)                nled[i] = 1'b0;
      else if (m_shd[i] == MAXV) nled[i] = 1'b1;
      else                     nled[i] = (m_shd[i] > m_cnt);
    end
    if (m_cnt == MAXV) begin
      for (int i = 0; i < 3; i++) m_shd[i] = m_duty[i];
    end
    if (tick) begin
      for (int i = 0; i < 3; i++) begin
        goal = rgb_target[i] ? MAXV : 0;
        if (m_duty[i] < goal)      m_duty[i] = m_duty[i] + 1;
        else if (m_duty[i] > goal) m_duty[i] = m_duty[i] - 1;
      end
    end
    m_tmr = (!ena || tick) ? 0 : m_tmr + 1;
    m_cnt = (m_cnt + 1) % (MAXV + 1);
    m_led = nled;
  endtask

  task automatic tick_cycle();
    exp_t e;
    exp_t g;
    model_clock();
    e.led = m_led;
    e.fad = model_fading();
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    check("led_pwm", int'(led_pwm), int'(g.led));
    check("fading", int'(fading), int'(g.fad));
  endtask

  task automatic apply_stimulus(input logic e, input logic [2:0] t, input int n);
    ena        = e;
    rgb_target = t;
    repeat (n) tick_cycle();
  endtask

  initial begin
    int hi;
    int win_exp;
    bit win_on;

    vecs[0] = '{1'b1, 3'b000, 100, 3'b000, 1'b0};
    vecs[1] = '{1'b1, 3'b001,  85, 3'b001, 1'b0};
    vecs[2] = '{1'b1, 3'b110,  85, 3'b110, 1'b0};
    vecs[3] = '{1'b0, 3'b111,  10, 3'b000, 1'b1};
    vecs[4] = '{1'b1, 3'b111,  90, 3'b111, 1'b0};
    vecs[5] = '{1'b1, 3'b000,  90, 3'b000, 1'b0};
    vecs[6] = '{1'b1, 3'b101,   1, 3'b000, 1'b1};
    vecs[7] = '{1'b1, 3'b000,  50, 3'b000, 1'b0};

    // Reset asserted between edges must clear outputs without a clock.
    rst_n      = 1'b1;
    ena        = 1'b1;
    rgb_target = 3'b111;
    #2 rst_n = 1'b0;
    #1;
    check("reset_led", int'(led_pwm), 0);
    check("reset_fading_111", int'(fading), 1);
    rgb_target = 3'b000;
    #1;
    check("reset_fading_000", int'(fading), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int v = 0; v < 8; v++) begin
      apply_stimulus(vecs[v].ena, vecs[v].tgt, vecs[v].cycles);
      check($sformatf("vec%0d_led", v), int'(led_pwm), int'(vecs[v].exp_led));
      check($sformatf("vec%0d_fading", v), int'(fading), int'(vecs[v].exp_fad));
    end

    // Fade up from 0 with the step timer aligned, counting high cycles per period.
    apply_stimulus(1'b0, 3'b000, 1);
    ena        = 1'b1;
    rgb_target = 3'b001;
    win_on     = 1'b0;
    hi         = 0;
    win_exp    = 0;
    for (int k = 1; k <= 93; k++) begin
      tick_cycle();
      if (k <= 45) check("fadeup_duty", int'(dut.duty_q[0]), k / 3);
      if (k == 44) check("fadeup_fading_44", int'(fading), 1);
      if (k == 45) check("fadeup_fading_45", int'(fading), 0);
      if (m_cnt == 1) begin
        win_on  = 1'b1;
        hi      = 0;
        win_exp = (m_shd[0] == MAXV) ? 16 : m_shd[0];
      end
      if (win_on) hi += int'(led_pwm[0]);
      if (win_on && m_cnt == 0) check("period_high_count", hi, win_exp);
    end
    check("fadeup_final_led", int'(led_pwm), 1);

    // Reversal mid-fade at duty 7.
    apply_stimulus(1'b1, 3'b000, 60);
    apply_stimulus(1'b0, 3'b000, 1);
    ena        = 1'b1;
    rgb_target = 3'b001;
    for (int k = 1; k <= 21; k++) begin
      tick_cycle();
      check("rev_up_duty", int'(dut.duty_q[0]), k / 3);
    end
    rgb_target = 3'b000;
    for (int k = 1; k <= 21; k++) begin
      tick_cycle();
      check("rev_down_duty", int'(dut.duty_q[0]), 7 - k / 3);
      if (k == 20) check("rev_fading_20", int'(fading), 1);
    end
    check("rev_fading_done", int'(fading), 0);
    repeat (17) tick_cycle();
    for (int k = 0; k < 16; k++) begin
      tick_cycle();
      check("rev_led_off", int'(led_pwm[0]), 0);
    end

    // Enable gating at duty 5.
    apply_stimulus(1'b0, 3'b000, 1);
    apply_stimulus(1'b1, 3'b001, 15);
    check("gate_duty_before", int'(dut.duty_q[0]), 5);
    ena = 1'b0;
    tick_cycle();
    check("gate_led_off", int'(led_pwm), 0);
    repeat (9) tick_cycle();
    check("gate_duty_frozen", int'(dut.duty_q[0]), 5);
    ena = 1'b1;
    tick_cycle();
    check("gate_resume_1", int'(dut.duty_q[0]), 5);
    tick_cycle();
    check("gate_resume_2", int'(dut.duty_q[0]), 5);
    tick_cycle();
    check("gate_resume_3", int'(dut.duty_q[0]), 6);

    // Async reset in the middle of a fade.
    apply_stimulus(1'b1, 3'b111, 90);
    check("pre_rst_led_full", int'(led_pwm), 7);
    apply_stimulus(1'b1, 3'b110, 20);
    check("pre_rst_led_hi", int'(led_pwm[2:1]), 3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_led", int'(led_pwm), 0);
    check("midrst_duty0", int'(dut.duty_q[0]), 0);
    check("midrst_duty1", int'(dut.duty_q[1]), 0);
    check("midrst_duty2", int'(dut.duty_q[2]), 0);
    check("midrst_fading", int'(fading), 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick_cycle();
    tick_cycle();
    check("restart_duty_2", int'(dut.duty_q[1]), 0);
    tick_cycle();
    check("restart_duty_3", int'(dut.duty_q[1]), 1);
    apply_stimulus(1'b1, 3'b110, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
